velocity_broadcast_ctrl: RTL and testbench

Motion-update broadcast controller. It sits directly upstream of the per-cell velocity caches. It accepts updated particle velocities tagged with a destination cell from the motion-update datapath over a valid/ready handshake and buffers them in a small FIFO. It drives the shared broadcast bus (`motion_update_enable`, data, destination cell, data valid) that every cell cache snoops, and it sequences the end of each motion-update phase so that the caches can commit their particle count and swap buffers before the next phase starts.

---
 rtl/velocity_broadcast_ctrl_if.sv | 43 ++++
 rtl/velocity_broadcast_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_velocity_broadcast_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/velocity_broadcast_ctrl_if.sv
// Handshake and broadcast bus bundle for velocity_broadcast_ctrl.
// master = upstream datapath / bus observer side, slave = the controller.
interface velocity_broadcast_ctrl_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [3*DATA_WIDTH-1:0]      in_data;
  logic [3*CELL_ID_WIDTH-1:0]   in_dst_cell;
  logic                         in_end;
  logic                         out_stall;
  logic                         motion_update_enable;
  logic [3*DATA_WIDTH-1:0]      out_data;
  logic [3*CELL_ID_WIDTH-1:0]   out_dst_cell;
  logic                         out_data_valid;

  modport master (
    output in_valid,
    output in_data,
    output in_dst_cell,
    output in_end,
    output out_stall,
    input  in_ready,
    input  motion_update_enable,
    input  out_data,
    input  out_dst_cell,
    input  out_data_valid
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dst_cell,
    input  in_end,
    input  out_stall,
    output in_ready,
    output motion_update_enable,
    output out_data,
    output out_dst_cell,
    output out_data_valid
  );
endinterface

// File: rtl/velocity_broadcast_ctrl.sv
// Motion-update broadcast controller: buffers tagged velocities and drives the cell-cache bus.
// Optional destination range filtering is enabled with `define DST_RANGE_CHECK_EN.
module velocity_broadcast_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int CELL_ID_WIDTH   = 4,
  parameter int CELL_DIM        = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter int SETTLE_CYCLES   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  velocity_broadcast_ctrl_if.slave bus,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              drop_count
);

  localparam int PAY_W = 3*DATA_WIDTH;
  localparam int CID_W = 3*CELL_ID_WIDTH;
  localparam int ENT_W = PAY_W + CID_W;
  localparam int CNT_W = FIFO_ADDR_WIDTH + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  if (FIFO_DEPTH != (1 << FIFO_ADDR_WIDTH)) begin : g_chk_depth
    $error("FIFO_DEPTH must equal 2**FIFO_ADDR_WIDTH");
  end
  if (SETTLE_CYCLES < 2) begin : g_chk_settle
    $error("SETTLE_CYCLES must be at least 2");
  end
  if (CELL_DIM < 1 || CELL_DIM >= (1 << CELL_ID_WIDTH)) begin : g_chk_dim
    $error("CELL_DIM must fit in CELL_ID_WIDTH bits");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       end_seen_q, end_seen_d;
  logic                       en_q, en_d;
  logic                       valid_q, valid_d;
  logic [PAY_W-1:0]           data_q, data_d;
  logic [CID_W-1:0]           dst_q, dst_d;
  logic [SET_W-1:0]           settle_q, settle_d;
  logic                       done_q, done_d;
  logic [15:0]                drop_q, drop_d;

  logic [ENT_W-1:0]           mem [FIFO_DEPTH];
  logic [ENT_W-1:0]           head;
  logic                       empty, full, accept, push, pop;

  assign empty        = (count_q == '0);
  // Full is judged on the pre-pop count, so a slot freed this cycle is not reused until the next.
  assign full         = (count_q == CNT_W'(FIFO_DEPTH));
  assign bus.in_ready = (state_q == STREAM) && !full && !end_seen_q;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = (state_q == STREAM) && !empty && !bus.out_stall;
  assign head         = mem[rd_ptr_q];

`ifdef DST_RANGE_CHECK_EN
  localparam logic [CELL_ID_WIDTH-1:0] DIM_MAX = CELL_ID_WIDTH'(CELL_DIM);

  function automatic logic coord_ok(input logic [CELL_ID_WIDTH-1:0] c);
    return (c != '0) && (c <= DIM_MAX);
  endfunction

  logic in_range;
  assign in_range = coord_ok(bus.in_dst_cell[3*CELL_ID_WIDTH-1:2*CELL_ID_WIDTH]) &&
                    coord_ok(bus.in_dst_cell[2*CELL_ID_WIDTH-1:CELL_ID_WIDTH])   &&
                    coord_ok(bus.in_dst_cell[CELL_ID_WIDTH-1:0]);
  assign push = accept && in_range;
`else
  assign push = accept;
`endif

  always_comb begin
    state_d    = state_q;
    end_seen_d = end_seen_q;
    en_d       = en_q;
    valid_d    = 1'b0;
    data_d     = '0;
    dst_d      = '0;
    settle_d   = settle_q;
    done_d     = 1'b0;
    drop_d     = drop_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = STREAM;
          en_d       = 1'b1;
          end_seen_d = 1'b0;
          drop_d     = '0;
        end
      end
      STREAM: begin
        if (bus.in_end) begin
          end_seen_d = 1'b1;
        end
        if (pop) begin
          valid_d = 1'b1;
          data_d  = head[PAY_W-1:0];
          dst_d   = head[ENT_W-1:PAY_W];
        end
`ifdef DST_RANGE_CHECK_EN
        if (accept && !in_range && (drop_q != '1)) begin
          drop_d = drop_q + 16'd1;
        end
`endif
        // No push can coincide with exit: in_ready is already low once end_seen is set.
        if (end_seen_q && empty && !pop) begin
          state_d  = SETTLE;
          en_d     = 1'b0;
          settle_d = SET_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(1)) begin
          state_d  = IDLE;
          settle_d = '0;
          done_d   = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      end_seen_q <= 1'b0;
      en_q       <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      dst_q      <= '0;
      settle_q   <= '0;
      done_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      end_seen_q <= end_seen_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      dst_q      <= dst_d;
      settle_q   <= settle_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {bus.in_dst_cell, bus.in_data};
    end
  end

  assign bus.motion_update_enable = en_q;
  assign bus.out_data_valid       = valid_q;
  assign bus.out_data             = data_q;
  assign bus.out_dst_cell         = dst_q;
  assign busy                     = (state_q != IDLE);
  assign done                     = done_q;
`ifdef DST_RANGE_CHECK_EN
  assign drop_count               = drop_q;
`else
  assign drop_count               = '0;
`endif

endmodule

// File: tb/tb_velocity_broadcast_ctrl.sv
// Scenario bench for velocity_broadcast_ctrl with a queue scoreboard of expected broadcasts.
module tb_velocity_broadcast_ctrl;
  localparam int DW     = 32;
  localparam int CW     = 4;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 3;
  localparam int PW     = 3*DW;
  localparam int DSTW   = 3*CW;

  typedef struct {
    logic [PW-1:0]   data;
    logic [DSTW-1:0] dst;
    int              when;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] drop_count;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  exp_t        sb[$];

  velocity_broadcast_ctrl_if #(.DATA_WIDTH(DW), .CELL_ID_WIDTH(CW)) bus();

  velocity_broadcast_ctrl #(
    .DATA_WIDTH(DW), .CELL_ID_WIDTH(CW), .CELL_DIM(4),
    .FIFO_DEPTH(DEPTH), .FIFO_ADDR_WIDTH(3), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] make_data(input int k);
    return {32'(k*7+3) ^ 32'hC0DE_0000, 32'(k*5+1), 32'(k) ^ 32'h1234_5678};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_end = 1'b0; bus.out_stall = 1'b0;
    bus.in_data = '0; bus.in_dst_cell = '0;
    step(); step();
    checks++; if (bus.motion_update_enable !== 1'b0) begin failures++; $display("FAIL rst_en got=%b exp=0", bus.motion_update_enable); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || bus.out_data_valid !== 1'b0) begin failures++; $display("FAIL rst_done_valid got=%b%b exp=00", done, bus.out_data_valid); end
    rst = 1'b0;
    step();
    start = 1'b1; step(); start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = make_data(50); bus.in_dst_cell = {4'd1, 4'd1, 4'd1};
    step();
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_data_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", bus.out_data_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.motion_update_enable !== 1'b0) begin failures++; $display("FAIL async_rst_en got=%b exp=0", bus.motion_update_enable); end
    checks++; if (bus.out_data_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", bus.out_data_valid); end
    checks++; if (bus.out_data !== '0 || bus.out_dst_cell !== '0) begin failures++; $display("FAIL async_rst_data got=%h/%h exp=0", bus.out_data, bus.out_dst_cell); end
    checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL async_rst_ready_busy got=%b%b exp=00", bus.in_ready, busy); end
    checks++; if (done !== 1'b0 || drop_count !== 16'd0) begin failures++; $display("FAIL async_rst_done_drop got=%b/%0d exp=0/0", done, drop_count); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    exp_t e;
    int last_valid = -1, fall_cyc = -1, done_cyc = -1, n_valid = 0, n_done = 0;
    logic prev_en;
    logic [DSTW-1:0] d = {4'd3, 4'd1, 4'd2};
    start = 1'b1; step(); start = 1'b0;
    checks++; if (bus.motion_update_enable !== 1'b1) begin failures++; $display("FAIL basic_en_at_start got=%b exp=1", bus.motion_update_enable); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_at_start got=%b exp=1", bus.in_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    prev_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (j < 3) begin
        bus.in_valid = 1'b1; bus.in_data = make_data(j); bus.in_dst_cell = d; bus.in_end = (j == 2);
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++; $display("FAIL basic_ready item=%0d got=%b exp=1", j, bus.in_ready);
        end else begin
          e.data = make_data(j); e.dst = d; e.when = cyc + 2; sb.push_back(e);
        end
      end else begin
        bus.in_valid = 1'b0; bus.in_end = 1'b0;
      end
      step();
      if (bus.out_data_valid === 1'b1) begin
        n_valid++; last_valid = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL basic_extra_bcast got=%h exp=none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.data || bus.out_dst_cell !== e.dst || cyc != e.when) begin
            failures++;
            $display("FAIL basic_bcast got=%h/%h@%0d exp=%h/%h@%0d", bus.out_data, bus.out_dst_cell, cyc, e.data, e.dst, e.when);
          end
        end
        checks++; if (bus.motion_update_enable !== 1'b1) begin failures++; $display("FAIL basic_en_with_valid got=%b exp=1", bus.motion_update_enable); end
      end
      if (prev_en === 1'b1 && bus.motion_update_enable === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
      prev_en = bus.motion_update_enable;
      if (done === 1'b1) begin
        n_done++; done_cyc = cyc;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
      end
    end
    checks++; if (n_valid != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", n_valid); end
    checks++; if (fall_cyc != last_valid + 1) begin failures++; $display("FAIL basic_en_fall got=%0d exp=%0d", fall_cyc, last_valid + 1); end
    checks++; if (done_cyc != fall_cyc + SETTLE) begin failures++; $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc, fall_cyc + SETTLE); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", n_done); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL basic_leftover got=%0d exp=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int k = 0, n_bc = 0, first = -1, last = -1, n_done = 0;
    logic [DSTW-1:0] d = {4'd1, 4'd2, 4'd3};
    bus.out_stall = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      bus.in_valid = 1'b1; bus.in_data = make_data(100 + k); bus.in_dst_cell = d; bus.in_end = 1'b0;
      if (bus.in_ready === 1'b1) begin
        e.data = make_data(100 + k); e.dst = d; e.when = 0; sb.push_back(e); k++;
      end
      step();
      checks++; if (bus.out_data_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_in_stall got=%b exp=0", bus.out_data_valid); end
    end
    checks++; if (k != DEPTH) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", k, DEPTH); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", bus.in_ready); end
    bus.out_stall = 1'b0;
    for (int j = 0; j < 40 && n_done == 0; j++) begin
      if (k < 10) begin
        bus.in_valid = 1'b1; bus.in_data = make_data(100 + k); bus.in_dst_cell = d;
        bus.in_end = (k == 9) && (bus.in_ready === 1'b1);
        if (bus.in_ready === 1'b1) begin
          e.data = make_data(100 + k); e.dst = d; e.when = 0; sb.push_back(e); k++;
        end
      end else begin
        bus.in_valid = 1'b0; bus.in_end = 1'b0;
      end
      step();
      if (bus.out_data_valid === 1'b1) begin
        n_bc++; if (first < 0) first = cyc; last = cyc;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bp_extra_bcast got=%h exp=none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.data || bus.out_dst_cell !== e.dst) begin
            failures++; $display("FAIL bp_order got=%h/%h exp=%h/%h", bus.out_data, bus.out_dst_cell, e.data, e.dst);
          end
        end
      end
      if (done === 1'b1) n_done++;
    end
    bus.in_valid = 1'b0; bus.in_end = 1'b0;
    checks++; if (n_bc != 10) begin failures++; $display("FAIL bp_bcast_count got=%0d exp=10", n_bc); end
    checks++; if (last - first != 9) begin failures++; $display("FAIL bp_bubbles got_span=%0d exp=9", last - first); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", n_done); end
    checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL bp_drop got=%0d exp=0", drop_count); end
    sb.delete();
  endtask

  task automatic test_empty_phase();
    int s, en_cycles = 0, n_valid = 0, n_done = 0, done_cyc = -1;
    start = 1'b1; step(); start = 1'b0;
    s = cyc;
    if (bus.motion_update_enable === 1'b1) en_cycles++;
    bus.in_end = 1'b1; step(); bus.in_end = 1'b0;
    if (bus.motion_update_enable === 1'b1) en_cycles++;
    for (int j = 0; j < 10; j++) begin
      start = (cyc == s + 2);
      step();
      start = 1'b0;
      if (bus.motion_update_enable === 1'b1) en_cycles++;
      if (bus.out_data_valid === 1'b1) n_valid++;
      if (done === 1'b1) begin n_done++; done_cyc = cyc; end
    end
    checks++; if (en_cycles != 2) begin failures++; $display("FAIL empty_en_cycles got=%0d exp=2", en_cycles); end
    checks++; if (n_valid != 0) begin failures++; $display("FAIL empty_valid got=%0d exp=0", n_valid); end
    checks++; if (done_cyc != s + 2 + SETTLE) begin failures++; $display("FAIL empty_done_time got=%0d exp=%0d", done_cyc, s + 2 + SETTLE); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL empty_done_pulses got=%0d exp=1", n_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_range();
    exp_t e;
    int n_bc = 0, n_done = 0;
    logic [DSTW-1:0] dsts [3];
    int exp_bc;
    logic [15:0] exp_drop;
    dsts[0] = {4'd0, 4'd1, 4'd2};
    dsts[1] = {4'd5, 4'd1, 4'd1};
    dsts[2] = {4'd4, 4'd4, 4'd4};
`ifdef DST_RANGE_CHECK_EN
    exp_bc = 1; exp_drop = 16'd2;
`else
    exp_bc = 3; exp_drop = 16'd0;
`endif
    start = 1'b1; step(); start = 1'b0;
    for (int j = 0; j < 14; j++) begin
      if (j < 3) begin
        bus.in_valid = 1'b1; bus.in_data = make_data(400 + j); bus.in_dst_cell = dsts[j]; bus.in_end = (j == 2);
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++; $display("FAIL range_ready item=%0d got=%b exp=1", j, bus.in_ready);
        end else if (exp_bc == 3 || j == 2) begin
          e.data = make_data(400 + j); e.dst = dsts[j]; e.when = cyc + 2; sb.push_back(e);
        end
      end else begin
        bus.in_valid = 1'b0; bus.in_end = 1'b0;
      end
      step();
      if (bus.out_data_valid === 1'b1) begin
        n_bc++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL range_extra_bcast got=%h exp=none", bus.out_dst_cell);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.data || bus.out_dst_cell !== e.dst) begin
            failures++; $display("FAIL range_bcast got=%h/%h exp=%h/%h", bus.out_data, bus.out_dst_cell, e.data, e.dst);
          end
        end
      end
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_bc != exp_bc) begin failures++; $display("FAIL range_count got=%0d exp=%0d", n_bc, exp_bc); end
    checks++; if (drop_count !== exp_drop) begin failures++; $display("FAIL range_drop got=%0d exp=%0d", drop_count, exp_drop); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL range_done got=%0d exp=1", n_done); end
    sb.delete();
  endtask

  task automatic test_midphase_reset();
    exp_t e;
    int n_bc = 0, n_done = 0;
    bus.out_stall = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus.in_valid = 1'b1; bus.in_data = make_data(200 + j); bus.in_dst_cell = {4'd2, 4'd2, 4'd2};
      step();
    end
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.motion_update_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_en got=%b exp=0", bus.motion_update_enable); end
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_busy_ready got=%b%b exp=00", busy, bus.in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      checks++; if (bus.out_data_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_stale_bcast got=%h exp=none", bus.out_data); end
    end
    start = 1'b1; step(); start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = make_data(300); bus.in_dst_cell = {4'd4, 4'd3, 4'd2}; bus.in_end = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL mid_new_ready got=%b exp=1", bus.in_ready);
    end else begin
      e.data = make_data(300); e.dst = {4'd4, 4'd3, 4'd2}; e.when = cyc + 2; sb.push_back(e);
    end
    step();
    bus.in_valid = 1'b0; bus.in_end = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (bus.out_data_valid === 1'b1) begin
        n_bc++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL mid_extra_bcast got=%h exp=none", bus.out_data);
        end else begin
          e = sb.pop_front();
          if (bus.out_data !== e.data || bus.out_dst_cell !== e.dst || cyc != e.when) begin
            failures++;
            $display("FAIL mid_new_bcast got=%h/%h@%0d exp=%h/%h@%0d", bus.out_data, bus.out_dst_cell, cyc, e.data, e.dst, e.when);
          end
        end
      end
      if (done === 1'b1) n_done++;
    end
    checks++; if (n_bc != 1) begin failures++; $display("FAIL mid_new_count got=%0d exp=1", n_bc); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL mid_new_done got=%0d exp=1", n_done); end
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_end = 1'b0; bus.out_stall = 1'b0;
    bus.in_data = '0; bus.in_dst_cell = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_phase();
    test_range();
    test_midphase_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
